// File: rtl/round_ctrl.sv
// round_ctrl: iterative sequencer for a 64-bit block cipher.
// Each round passes the state through an external substitution/shuffle stage
// (sub_drv -> sub_ret) and then XORs in the round key. The state is whitened
// with WK = K0 ^ K1 on entry and again after the final round.
module round_ctrl #(
  parameter int ROUNDS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  pt,
  input  logic [127:0] key,
  output logic [63:0]  sub_drv,
  input  logic [63:0]  sub_ret,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  ct,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for a pt/key pair, in_ready high
  // RUN   | one round per clock edge, substitution stage in the loop
  // DONE  | ciphertext held on ct until out_ready

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  generate
    if (ROUNDS < 2 || ROUNDS > 63) begin : g_bad_rounds
      $error("round_ctrl: ROUNDS must lie within 2..63");
    end
  endgenerate

  localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

  state_e        state_q, state_d;
  logic [63:0]   data_q,  data_d;
  logic [127:0]  key_q,   key_d;
  logic [5:0]    rnd_q,   rnd_d;

  logic [63:0]   k0, k1, wk, rk;

  // Key schedule from the latched key: even rounds use K0, odd rounds K1,
  // each tweaked by the round number so identical halves still differ.
  assign k0 = key_q[63:0];
  assign k1 = key_q[127:64];
  assign wk = k0 ^ k1;
  assign rk = (rnd_q[0] ? k1 : k0) ^ {58'b0, rnd_q};

  assign sub_drv   = data_q;
  assign ct        = data_q;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  // Next-state and datapath update; the fresh key is used directly at the
  // accept edge because key_q is not yet loaded.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          key_d   = key;
          data_d  = pt ^ key[63:0] ^ key[127:64];
          rnd_d   = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rnd_q == LAST_RND) begin
          data_d  = sub_ret ^ rk ^ wk;
          state_d = DONE;
        end else begin
          data_d = sub_ret ^ rk;
          rnd_d  = rnd_q + 6'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and key registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 64'h0;
      key_q   <= 128'h0;
      rnd_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl: two instances (ROUNDS=2 in loopback, ROUNDS=16 with a
// selectable loopback or S-box/shuffle stage) checked against a cipher
// reference computed directly from the round equations.
module tb_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;

  function automatic logic [63:0] sub_fn(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = SBOX[4*x[4*i +: 4] +: 4];
    return {y[50:0], y[63:51]};
  endfunction

  function automatic logic [63:0] golden(input logic [63:0] p, input logic [127:0] k,
                                         input int rounds, input logic sb);
    logic [63:0] k0, k1, s;
    k0 = k[63:0];
    k1 = k[127:64];
    s  = p ^ k0 ^ k1;
    for (int r = 0; r < rounds; r++)
      s = (sb ? sub_fn(s) : s) ^ ((r % 2 == 0) ? k0 : k1) ^ 64'(r);
    return s ^ k0 ^ k1;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instance A: ROUNDS=2, loopback ----------------
  logic          a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
  logic [63:0]   a_pt = '0, a_sub_drv, a_ct;
  logic [127:0]  a_key = '0;

  round_ctrl #(.ROUNDS(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .pt(a_pt), .key(a_key), .sub_drv(a_sub_drv), .sub_ret(a_sub_drv),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .ct(a_ct), .busy(a_busy)
  );

  // ---------------- instance B: ROUNDS=16 ----------------
  logic          b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [63:0]   b_pt = '0, b_sub_drv, b_sub_ret, b_ct;
  logic [127:0]  b_key = '0;
  logic          b_sbox_en = 1'b0;

  assign b_sub_ret = b_sbox_en ? sub_fn(b_sub_drv) : b_sub_drv;

  round_ctrl #(.ROUNDS(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .pt(b_pt), .key(b_key), .sub_drv(b_sub_drv), .sub_ret(b_sub_ret),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .ct(b_ct), .busy(b_busy)
  );

  // Reference for B: -1 = idle, N>0 = edges left before ciphertext, 0 = holding ct.
  int          m_left = -1;
  logic [63:0] m_ct   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = -1;
    end else if (m_left < 0) begin
      if (b_in_valid) begin
        m_left = 16;
        m_ct   = golden(b_pt, b_key, 16, b_sbox_en);
      end
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end else if (b_out_ready) begin
      m_left = -1;
    end
  end

  // Per-cycle comparison of B against the reference.
  always @(negedge clk) begin
    check1("b_in_ready", b_in_ready, m_left < 0);
    check1("b_busy", b_busy, m_left >= 0);
    check1("b_out_valid", b_out_valid, m_left == 0);
    if (m_left == 0) check64("b_ct", b_ct, m_ct);
    if (!rst_n) check64("b_ct_reset", b_ct, 64'h0);
  end

  task automatic run_a(input logic [63:0] p, input logic [127:0] k, input logic [63:0] exp_ct);
    int n;
    a_pt = p; a_key = k; a_in_valid = 1'b1;
    check1("a_ready_before", a_in_ready, 1'b1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_pt = ~p; a_key = ~k;
    n = 1;
    while (!a_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check64("a_latency_edges", 64'(n), 64'd3);
    check64("a_ct", a_ct, exp_ct);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check1("a_idle_after", a_busy, 1'b0);
  endtask

  task automatic b_wait_valid(input int budget, output int edges);
    edges = 0;
    while (!b_out_valid && edges < budget) begin
      @(posedge clk); #1;
      edges++;
    end
    check1("b_valid_timeout", b_out_valid, 1'b1);
  endtask

  initial begin
    int n;
    logic hs, go, abort;
    abort = 1'b0;

    @(posedge clk); #1;
    check1("a_rst_in_ready", a_in_ready, 1'b1);
    check1("a_rst_busy", a_busy, 1'b0);
    check1("a_rst_out_valid", a_out_valid, 1'b0);
    check64("a_rst_ct", a_ct, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reference pinned to hand-derived values.
    check64("gold_r2", golden(64'h0123456789ABCDEF, 128'h0, 2, 1'b0), 64'h0123456789ABCDEE);
    check64("gold_r16", golden(64'hFFFF0000AAAA5555, 128'h0, 16, 1'b0), 64'hFFFF0000AAAA5555);
    // WK cancels and K0 ^ K1 ^ RC(1) = 1 ^ 0 ^ 1 = 0, leaving pt = 0.
    check64("gold_wk", golden(64'h0, {64'h0, 64'h1}, 2, 1'b0), 64'h0);

    run_a(64'h0123456789ABCDEF, 128'h0, 64'h0123456789ABCDEE);
    run_a(64'h0, {64'h0, 64'h1}, 64'h0);

    // B: ROUNDS=16 loopback, then a long DONE stall with ignored in_valid.
    b_pt = 64'hFFFF0000AAAA5555; b_key = 128'h0; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_wait_valid(40, n);
    check64("b_latency_edges", 64'(n), 64'd16);
    check64("b_ct_r16", b_ct, 64'hFFFF0000AAAA5555);
    for (int i = 0; i < 10; i++) begin
      b_in_valid = 1'(i % 2);
      b_pt = {$urandom, $urandom};
      @(posedge clk); #1;
      check1("b_stall_valid", b_out_valid, 1'b1);
      check64("b_stall_ct", b_ct, 64'hFFFF0000AAAA5555);
    end
    b_out_ready = 1'b1; b_in_valid = 1'b1;
    b_pt = 64'h1122334455667788; b_key = 128'h0F0E0D0C0B0A09080706050403020100;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check1("b_hs_ready", b_in_ready, 1'b1);
    check1("b_hs_busy", b_busy, 1'b0);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    check1("b_accept_next", b_busy, 1'b1);
    b_wait_valid(40, n);
    check64("b_ct_after_stall", b_ct,
            golden(64'h1122334455667788, 128'h0F0E0D0C0B0A09080706050403020100, 16, 1'b0));
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;

    // Reset mid-RUN after five rounds, then a clean pair with the S-box stage.
    b_sbox_en = 1'b1;
    b_pt = 64'hDEADBEEFCAFEF00D; b_key = {$urandom, $urandom, $urandom, $urandom};
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check1("rst_out_valid", b_out_valid, 1'b0);
    check1("rst_busy", b_busy, 1'b0);
    check1("rst_in_ready", b_in_ready, 1'b1);
    check64("rst_ct", b_ct, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    b_pt = 64'h0123456789ABCDEF; b_key = 128'h00112233445566778899AABBCCDDEEFF;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_wait_valid(40, n);
    check64("post_rst_ct", b_ct,
            golden(64'h0123456789ABCDEF, 128'h00112233445566778899AABBCCDDEEFF, 16, 1'b1));
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;

    // Random vectors: inputs scrambled after accept, random out_ready stalls.
    for (int v = 0; v < 1000 && !abort; v++) begin
      b_pt = {$urandom, $urandom};
      b_key = {$urandom, $urandom, $urandom, $urandom};
      b_in_valid = 1'b1;
      @(posedge clk); #1;
      hs = 1'b0;
      n = 0;
      while (!hs && n < 60) begin
        b_in_valid = 1'($urandom_range(0, 1));
        b_pt = {$urandom, $urandom};
        b_key = {$urandom, $urandom, $urandom, $urandom};
        b_out_ready = ($urandom_range(0, 2) == 0);
        go = b_out_valid && b_out_ready;
        @(posedge clk); #1;
        n++;
        hs = go;
      end
      b_in_valid = 1'b0;
      b_out_ready = 1'b0;
      check1("rand_handshake", hs, 1'b1);
      if (!hs) abort = 1'b1;
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
